vga_fb_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between the VGA scan-out

---
 rtl/vga_fb_pkg.sv | 19 +
 rtl/fb_wr_fifo.sv | 77 +++++++
 rtl/vga_fb_arbiter.sv | 138 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared framebuffer geometry and RAM grant encoding
//
// Purpose : constants shared by the framebuffer arbiter and the VGA pixel
//           fetch logic: default RAM address/data widths and the encoding of
//           which requester owns the single RAM port in a given cycle.
// Ports   : none (package).
package vga_fb_pkg;

  localparam int unsigned FB_ADDR_W = 14;
  localparam int unsigned FB_DATA_W = 8;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;  // RAM idle
  localparam gnt_t GNT_DISP = 2'd1;  // display scan-out read
  localparam gnt_t GNT_HRD  = 2'd2;  // host read
  localparam gnt_t GNT_HWR  = 2'd3;  // host write drained from the FIFO

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - host write FIFO holding {addr,data} pairs
//
// Purpose : small synchronous FIFO that parks host writes until the arbiter
//           finds a free RAM cycle. Head entry is visible combinationally.
// Ports   : CLK, RST          clock, synchronous active-high reset (empties)
//           push, push_addr,
//           push_data         enqueue one write (ignored when full)
//           pop               dequeue the head (ignored when empty)
//           full, empty       occupancy flags
//           head_addr,
//           head_data         oldest queued write
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 14,
  parameter int unsigned DW    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW+DW-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Simultaneous push and pop leaves the count unchanged; the pop reads the
  // old head because the new entry lands at wr_ptr, never at rd_ptr while
  // the FIFO is non-empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: the occupancy count guards it.
  always_ff @(posedge CLK) begin
    if (do_push) store_q[wr_ptr_q] <= {push_addr, push_data};
  end

  assign {head_addr, head_data} = store_q[rd_ptr_q];

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer RAM arbiter, display first
//
// Purpose : shares one synchronous single-port framebuffer RAM between the VGA
//           scan-out reader (absolute priority, fixed 1-cycle read latency)
//           and a host port whose writes are buffered and drained into free
//           cycles. Host reads wait for the write FIFO to empty so
//           read-after-write order holds.
// Ports   : CLK, RST                  clock, synchronous active-high reset
//           disp_req/disp_addr        display read request
//           disp_rvalid/disp_rdata    display read return
//           host_valid/host_we/
//           host_addr/host_wdata      host request
//           host_ready                host request accepted this cycle
//           host_rvalid/host_rdata    host read return
//           mem_addr/mem_we/
//           mem_wdata/mem_rdata       framebuffer RAM port
//           stat_clr                  zero the stall counter
//           host_stall                saturating count of blocked host cycles
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned DATA_W      = FB_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   disp_req,
  input  logic [ADDR_W-1:0]      disp_addr,
  output logic                   disp_rvalid,
  output logic [DATA_W-1:0]      disp_rdata,
  input  logic                   host_valid,
  input  logic                   host_we,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic                   host_ready,
  output logic                   host_rvalid,
  output logic [DATA_W-1:0]      host_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   stat_clr,
  output logic [STALL_CNT_W-1:0] host_stall
);

  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_push, fifo_pop;

  gnt_t gnt;
  gnt_t last_gnt_q, last_gnt_d;

  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   host_blocked;

  fb_wr_fifo #(
    .DEPTH (WFIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wr_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_addr (host_addr),
    .push_data (host_wdata),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // Fixed-priority grant. A drain is suppressed while RST is high so that
  // writes discarded by reset never reach the RAM.
  always_comb begin
    gnt = GNT_NONE;
    if (disp_req)
      gnt = GNT_DISP;
    else if (host_valid && !host_we && fifo_empty)
      gnt = GNT_HRD;
    else if (!fifo_empty && !RST)
      gnt = GNT_HWR;
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (gnt)
      GNT_DISP: mem_addr = disp_addr;
      GNT_HRD:  mem_addr = host_addr;
      GNT_HWR: begin
        mem_addr  = head_addr;
        mem_we    = 1'b1;
        mem_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Reads need the RAM this very cycle and an empty FIFO (read-after-write);
  // writes only need FIFO space.
  assign host_ready   = host_we ? !fifo_full : (fifo_empty && !disp_req);
  assign fifo_push    = host_valid && host_we && !fifo_full;
  assign fifo_pop     = (gnt == GNT_HWR);
  assign host_blocked = host_valid && !host_ready;

  assign last_gnt_d = gnt;

  always_comb begin
    stall_d = stall_q;
    if (stat_clr)
      stall_d = '0;
    else if (host_blocked && !(&stall_q))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt_q <= GNT_NONE;
      stall_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      stall_q    <= stall_d;
    end
  end

  // RAM data is shared; the registered grant says whose read it is.
  assign disp_rvalid = (last_gnt_q == GNT_DISP);
  assign host_rvalid = (last_gnt_q == GNT_HRD);
  assign disp_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign host_stall  = stall_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized and directed bench against a queue model
module tb_vga_fb_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          host_valid = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          stat_clr = 1'b0;
  logic [SW-1:0] host_stall;

  vga_fb_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WFIFO_DEPTH (4),
    .STALL_CNT_W (SW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stat_clr    (stat_clr),
    .host_stall  (host_stall)
  );

  always #5 CLK = ~CLK;

  // Framebuffer RAM seen by the DUT.
  logic [DW-1:0] ram [1 << AW];
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: expected RAM image, pending-write queue, last read owner.
  typedef struct { int a; int d; } wr_t;
  wr_t q[$];
  int  model_mem [1 << AW];
  int  m_last  = 0;   // 0 none, 1 display read, 2 host read
  int  m_rdata = 0;
  int  m_stall = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Called at 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    int  eg, ea;
    bit  er, do_push;
    #4;
    er = host_we ? (q.size() < 4) : (q.size() == 0 && !disp_req);
    if (disp_req) begin eg = 1; ea = int'(disp_addr); end
    else if (host_valid && !host_we && q.size() == 0) begin eg = 2; ea = int'(host_addr); end
    else if (q.size() != 0 && !RST) begin eg = 3; ea = q[0].a; end
    else begin eg = 0; ea = 0; end

    chk("disp_rvalid", disp_rvalid, m_last == 1);
    if (m_last == 1) chk("disp_rdata", disp_rdata, m_rdata);
    chk("host_rvalid", host_rvalid, m_last == 2);
    if (m_last == 2) chk("host_rdata", host_rdata, m_rdata);
    chk("host_stall", host_stall, m_stall);
    chk("host_ready", host_ready, er);
    chk("mem_we", mem_we, eg == 3);
    chk("mem_addr", mem_addr, ea);
    if (eg == 3) chk("mem_wdata", mem_wdata, q[0].d);

    if (RST) begin
      q.delete();
      m_last  = 0;
      m_stall = 0;
    end else begin
      do_push = host_valid && host_we && (q.size() < 4);
      m_last  = (eg == 1 || eg == 2) ? eg : 0;
      if (eg == 1 || eg == 2) m_rdata = model_mem[ea];
      if (eg == 3) begin
        model_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{int'(host_addr), int'(host_wdata)});
      if (stat_clr) m_stall = 0;
      else if (host_valid && !er && m_stall < SMAX) m_stall++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    disp_req = 0; host_valid = 0; host_we = 0; stat_clr = 0; RST = 0;
  endtask

  initial begin
    int s0;
    bit acc;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]       = DW'(i * 7 + 3);
      model_mem[i] = (i * 7 + 3) & 8'hFF;
    end

    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    // Reset state while RST still high: no rvalid, stall 0, writes allowed.
    host_we = 1;
    step();
    chk("rst_ready_wr", host_ready, 1);
    chk("rst_stall", host_stall, 0);
    idle();

    // 1: single host write drains on the next free cycle.
    host_valid = 1; host_we = 1; host_addr = 14'h0010; host_wdata = 8'hA5;
    #4; chk("t1_ready", host_ready, 1); #0;
    @(posedge CLK); #1;
    // The edge above is the push; replay it through the model.
    q.push_back('{16, 8'hA5});
    idle();
    #4;
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 14'h0010);
    chk("t1_wdata", mem_wdata, 8'hA5);
    @(posedge CLK); #1;
    model_mem[16] = 8'hA5;
    void'(q.pop_front());
    step();

    // 2: display priority, three writes pushed under a 10-cycle display burst.
    for (int i = 0; i < 10; i++) begin
      disp_req = 1; disp_addr = AW'(100 + i);
      host_valid = (i < 3); host_we = 1; host_addr = AW'(i); host_wdata = DW'(8'h50 + i);
      step();
    end
    idle();
    repeat (4) step();

    // 3: FIFO full under display, fifth write stalls and counts.
    stat_clr = 1; step(); stat_clr = 0;
    for (int i = 0; i < 4; i++) begin
      disp_req = 1; host_valid = 1; host_we = 1; host_addr = AW'(20 + i); host_wdata = DW'($urandom);
      step();
    end
    s0 = int'(host_stall);
    host_addr = 24;
    repeat (3) step();
    chk("t3_ready", host_ready, 0);
    chk("t3_stall", host_stall, s0 + 3);
    idle();
    repeat (6) step();

    // 4: read-after-write ordering under intermittent display.
    host_valid = 1; host_we = 1; host_addr = 5; host_wdata = 8'h3C;
    disp_req = 1;
    step();
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      disp_req = (i % 3 != 1); host_valid = 1; host_we = 0; host_addr = 5;
      acc = (q.size() == 0 && !disp_req);
      step();
    end
    chk("t4_accept", acc, 1);
    chk("t4_rvalid", host_rvalid, 1);
    chk("t4_rdata", host_rdata, 8'h3C);
    idle();
    step();

    // 5: reset with writes queued, then reset coinciding with a host read grant.
    disp_req = 1; host_valid = 1; host_we = 1;
    host_addr = 30; host_wdata = 8'h11; step();
    host_addr = 31; host_wdata = 8'h22; step();
    disp_req = 0; host_valid = 0; RST = 1; step();
    RST = 0;
    repeat (2) step();
    host_valid = 1; host_we = 0; host_addr = 31; RST = 1; step();
    chk("t5_no_rvalid", host_rvalid, 0);
    chk("t5_stall", host_stall, 0);
    RST = 0; host_valid = 1; host_we = 0; host_addr = 30; step();
    idle(); step();

    // 6: stall counter saturates, then clears.
    disp_req = 1; host_valid = 1; host_we = 0; host_addr = 3;
    repeat (20) step();
    chk("t6_sat", host_stall, 15);
    stat_clr = 1; step();
    chk("t6_clr", host_stall, 0);
    idle(); step();

    // Randomized traffic with bursty display requests.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) disp_req = ~disp_req;
      disp_addr  = AW'($urandom);
      host_valid = ($urandom_range(0, 9) < 6);
      host_we    = $urandom_range(0, 1);
      host_addr  = AW'($urandom_range(0, 15));
      host_wdata = DW'($urandom);
      stat_clr   = ($urandom_range(0, 49) == 0);
      RST        = ($urandom_range(0, 199) == 0);
      step();
    end
    idle();
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
